// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID/EX pipeline and the hazard/forwarding unit.
// The pipeline side is master; the unit is slave.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int PERF_W  = 32
);
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic                      id_valid;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_memread;
  logic [REG_AW-1:0]         mem_rd;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic                      wb_regwrite;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      forward_sel;
  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic [PERF_W-1:0]         stall_cnt;

  modport master (
    output ex_rs, ex_rs_used, id_rs, id_rs_used,
    output id_valid, ex_rd, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output flush,
    input  forward_sel, stall_if, stall_id,
    input  bubble_ex, stall_cnt
  );

  modport slave (
    input  ex_rs, ex_rs_used, id_rs, id_rs_used,
    input  id_valid, ex_rd, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  flush,
    output forward_sel, stall_if, stall_id,
    output bubble_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX operand bypass selects plus a load-use stall FSM.
// Flush beats any stall; the stall-cycle counter saturates.
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_forward_unit_if.slave hfu
);
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  typedef enum logic {IDLE, STALL} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  logic [NUM_SRC-1:0]   mem_hit;
  logic [NUM_SRC-1:0]   wb_hit;
  logic [NUM_SRC-1:0]   id_hit;
  logic [2*NUM_SRC-1:0] fwd;
  logic                 hz;
  logic                 stall;

  // wb_hit is masked by mem_hit so the newer MEM result always wins
  always_comb begin
    mem_hit = '0;
    wb_hit  = '0;
    id_hit  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mem_hit[i] = hfu.ex_rs_used[i] && hfu.mem_regwrite &&
                   (hfu.mem_rd != '0) &&
                   (hfu.ex_rs[i*REG_AW +: REG_AW] == hfu.mem_rd);
      wb_hit[i]  = hfu.ex_rs_used[i] && hfu.wb_regwrite &&
                   (hfu.wb_rd != '0) &&
                   (hfu.ex_rs[i*REG_AW +: REG_AW] == hfu.wb_rd) &&
                   !mem_hit[i];
      id_hit[i]  = hfu.id_rs_used[i] &&
                   (hfu.id_rs[i*REG_AW +: REG_AW] == hfu.ex_rd);
    end
  end

  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[2*i +: 2] = {wb_hit[i], mem_hit[i]};
    end
  end

  assign hz = hfu.id_valid && hfu.ex_memread &&
              (hfu.ex_rd != '0) && (|id_hit);

  always_comb begin
    stall = 1'b0;
    if (!rst && !hfu.flush) begin
      unique case (state_q)
        IDLE:    stall = hz;
        STALL:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (hfu.flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // single-cycle latency needs no extra state
            if (hz && (LOAD_LAT > 1)) begin
              state_q <= STALL;
              cnt_q   <= CNT_INIT;
            end
          end
          STALL: begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign hfu.forward_sel = rst ? '0 : fwd;
  assign hfu.stall_if    = stall;
  assign hfu.stall_id    = stall;
  assign hfu.bubble_ex   = stall;
  assign hfu.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (3 src/lat 3/4-bit perf,
// 2 src/lat 1/32-bit perf) against a cycle-level reference model.
module tb_hazard_forward_unit;
  localparam int AW    = 5;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int rem_a = 0;
  int rem_b = 0;
  longint cnt_a = 0;
  longint cnt_b = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(AW), .NUM_SRC(3), .PERF_W(4))  ia ();
  hazard_forward_unit_if #(.REG_AW(AW), .NUM_SRC(2), .PERF_W(32)) ib ();

  hazard_forward_unit #(
    .REG_AW(AW), .NUM_SRC(3), .LOAD_LAT(LAT_A), .PERF_W(4)
  ) dut_a (.clk(clk), .rst(rst), .hfu(ia.slave));

  hazard_forward_unit #(
    .REG_AW(AW), .NUM_SRC(2), .LOAD_LAT(LAT_B), .PERF_W(32)
  ) dut_b (.clk(clk), .rst(rst), .hfu(ib.slave));

  function automatic logic [5:0] ref_fwd(
    input int n, input logic [14:0] rs, input logic [2:0] used,
    input int mrd, input logic mw, input int wrd, input logic ww);
    logic [5:0] r;
    int a;
    r = '0;
    for (int i = 0; i < n; i++) begin
      a = int'(rs[i*AW +: AW]);
      if (used[i] && a != 0 && mw && a == mrd) r[2*i +: 2] = 2'd1;
      else if (used[i] && a != 0 && ww && a == wrd) r[2*i +: 2] = 2'd2;
    end
    return r;
  endfunction

  function automatic logic ref_hz(
    input int n, input logic [14:0] rs, input logic [2:0] used,
    input logic valid, input logic memread, input int exrd);
    logic any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (used[i] && int'(rs[i*AW +: AW]) == exrd) any = 1'b1;
    end
    return valid && memread && exrd != 0 && any;
  endfunction

  task automatic clear_inputs();
    ia.ex_rs = '0; ia.ex_rs_used = '0; ia.id_rs = '0; ia.id_rs_used = '0;
    ia.id_valid = 0; ia.ex_rd = '0; ia.ex_memread = 0;
    ia.mem_rd = '0; ia.mem_regwrite = 0; ia.wb_rd = '0; ia.wb_regwrite = 0;
    ia.flush = 0;
    ib.ex_rs = '0; ib.ex_rs_used = '0; ib.id_rs = '0; ib.id_rs_used = '0;
    ib.id_valid = 0; ib.ex_rd = '0; ib.ex_memread = 0;
    ib.mem_rd = '0; ib.mem_regwrite = 0; ib.wb_rd = '0; ib.wb_regwrite = 0;
    ib.flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
  endtask

  task automatic set_hazard_a(input logic on, input logic [4:0] rd);
    ia.id_valid = on; ia.ex_memread = on; ia.ex_rd = rd;
    ia.id_rs = {5'd0, rd, 5'd0}; ia.id_rs_used = 3'b010;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ia.ex_rs = {5'd3, 5'd7, 5'd3}; ia.ex_rs_used = 3'b111;
    ia.mem_rd = 5'd3; ia.mem_regwrite = 1; ia.wb_rd = 5'd7; ia.wb_regwrite = 1;
    set_hazard_a(1'b1, 5'd7);
    ib.ex_rs = {5'd2, 5'd2}; ib.ex_rs_used = 2'b11;
    ib.mem_rd = 5'd2; ib.mem_regwrite = 1;
    ib.id_valid = 1; ib.ex_memread = 1; ib.ex_rd = 5'd2;
    ib.id_rs = {5'd2, 5'd2}; ib.id_rs_used = 2'b11;
    #1;
    tests++;
    if (ia.forward_sel !== 6'b0 || ib.forward_sel !== 4'b0) begin
      fails++;
      $display("FAIL reset_fwd got a=%b b=%b want 0", ia.forward_sel, ib.forward_sel);
    end
    tests++;
    if ({ia.stall_if, ia.stall_id, ia.bubble_ex, ib.stall_if, ib.stall_id,
         ib.bubble_ex} !== 6'b0 || ia.stall_cnt !== 4'd0 || ib.stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_ctl got stall_a=%b stall_b=%b cnt_a=%0d cnt_b=%0d want 0",
               ia.stall_if, ib.stall_if, ia.stall_cnt, ib.stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ia.forward_sel !== 6'b01_10_01) begin
      fails++;
      $display("FAIL release_fwd got %b want 011001", ia.forward_sel);
    end
    do_reset();
  endtask

  task automatic test_fwd_directed();
    @(negedge clk);
    ib.ex_rs = {5'd0, 5'd5}; ib.ex_rs_used = 2'b01;
    ib.mem_rd = 5'd5; ib.mem_regwrite = 1; ib.wb_rd = 5'd5; ib.wb_regwrite = 1;
    #1;
    tests++;
    if (ib.forward_sel !== 4'b0001) begin
      fails++; $display("FAIL fwd_mem_prio got %b want 0001", ib.forward_sel);
    end
    ib.mem_regwrite = 0;
    #1;
    tests++;
    if (ib.forward_sel !== 4'b0010) begin
      fails++; $display("FAIL fwd_wb got %b want 0010", ib.forward_sel);
    end
    ib.ex_rs_used = 2'b00;
    #1;
    tests++;
    if (ib.forward_sel !== 4'b0000) begin
      fails++; $display("FAIL fwd_unused got %b want 0000", ib.forward_sel);
    end
    ia.ex_rs = {5'd3, 5'd7, 5'd3}; ia.ex_rs_used = 3'b111;
    ia.mem_rd = 5'd3; ia.mem_regwrite = 1; ia.wb_rd = 5'd7; ia.wb_regwrite = 1;
    #1;
    tests++;
    if (ia.forward_sel !== 6'b01_10_01) begin
      fails++; $display("FAIL fwd_3src got %b want 011001", ia.forward_sel);
    end
    ia.ex_rs = '0; ia.mem_rd = '0; ia.wb_rd = '0;
    #1;
    tests++;
    if (ia.forward_sel !== 6'b0) begin
      fails++; $display("FAIL fwd_x0 got %b want 000000", ia.forward_sel);
    end
    clear_inputs();
  endtask

  task automatic test_stall_lat1();
    do_reset();
    @(negedge clk);
    ib.id_valid = 1; ib.ex_memread = 1; ib.ex_rd = 5'd4;
    ib.id_rs = {5'd0, 5'd4}; ib.id_rs_used = 2'b01;
    #1;
    tests++;
    if ({ib.stall_if, ib.stall_id, ib.bubble_ex} !== 3'b111) begin
      fails++; $display("FAIL lat1_stall got %b want 111", ib.stall_if);
    end
    @(negedge clk);
    ib.ex_memread = 0; ib.ex_rd = '0;
    #1;
    tests++;
    if ({ib.stall_if, ib.stall_id, ib.bubble_ex} !== 3'b000 || ib.stall_cnt !== 32'd1) begin
      fails++;
      $display("FAIL lat1_after got stall=%b cnt=%0d want 0 cnt=1", ib.stall_if, ib.stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_stall_lat3();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_hazard_a(c == 0, (c == 0) ? 5'd4 : 5'd0);
      #1;
      tests++;
      if ({ia.stall_if, ia.stall_id, ia.bubble_ex} !== {3{c < 3}}) begin
        fails++;
        $display("FAIL lat3_stall c=%0d got %b%b%b want %0d", c,
                 ia.stall_if, ia.stall_id, ia.bubble_ex, c < 3);
      end
    end
    tests++;
    if (ia.stall_cnt !== 4'd3) begin
      fails++; $display("FAIL lat3_cnt got %0d want 3", ia.stall_cnt);
    end
    @(negedge clk);
    set_hazard_a(1'b1, 5'd0);
    #1;
    tests++;
    if (ia.stall_if !== 1'b0) begin
      fails++; $display("FAIL lat3_x0 got %b want 0", ia.stall_if);
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    set_hazard_a(1'b1, 5'd9);
    #1;
    tests++;
    if (ia.stall_if !== 1'b1) begin
      fails++; $display("FAIL flush_c0 got %b want 1", ia.stall_if);
    end
    @(negedge clk);
    ia.flush = 1;
    #1;
    tests++;
    if ({ia.stall_if, ia.stall_id, ia.bubble_ex} !== 3'b000) begin
      fails++; $display("FAIL flush_c1 got %b want 0", ia.stall_if);
    end
    @(negedge clk);
    ia.flush = 0;
    set_hazard_a(1'b0, 5'd0);
    #1;
    tests++;
    if (ia.stall_if !== 1'b0 || ia.stall_cnt !== 4'd1) begin
      fails++;
      $display("FAIL flush_c2 got stall=%b cnt=%0d want 0 cnt=1", ia.stall_if, ia.stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_saturate_reset();
    do_reset();
    @(negedge clk);
    set_hazard_a(1'b1, 5'd6);
    ia.ex_rs = {5'd0, 5'd0, 5'd8}; ia.ex_rs_used = 3'b001;
    ia.mem_rd = 5'd8; ia.mem_regwrite = 1;
    repeat (22) @(negedge clk);
    #1;
    tests++;
    if (ia.stall_cnt !== 4'd15 || ia.stall_if !== 1'b1) begin
      fails++;
      $display("FAIL saturate got cnt=%0d stall=%b want 15 stall=1", ia.stall_cnt, ia.stall_if);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ia.stall_if, ia.stall_id, ia.bubble_ex} !== 3'b000 ||
        ia.forward_sel !== 6'b0 || ia.stall_cnt !== 4'd0) begin
      fails++;
      $display("FAIL async_rst got stall=%b fwd=%b cnt=%0d want 0", ia.stall_if,
               ia.forward_sel, ia.stall_cnt);
    end
    set_hazard_a(1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ia.stall_if !== 1'b0 || ia.forward_sel !== 6'b000001) begin
      fails++;
      $display("FAIL post_rst got stall=%b fwd=%b want 0 000001", ia.stall_if, ia.forward_sel);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [5:0] ef;
    logic hz;
    logic st;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ia.ex_rs[i*AW +: AW] = 5'($urandom_range(0, 3));
        ia.id_rs[i*AW +: AW] = 5'($urandom_range(0, 3));
      end
      for (int i = 0; i < 2; i++) begin
        ib.ex_rs[i*AW +: AW] = 5'($urandom_range(0, 3));
        ib.id_rs[i*AW +: AW] = 5'($urandom_range(0, 3));
      end
      ia.ex_rs_used = 3'($urandom); ia.id_rs_used = 3'($urandom);
      ib.ex_rs_used = 2'($urandom); ib.id_rs_used = 2'($urandom);
      ia.id_valid = 1'($urandom); ia.ex_memread = 1'($urandom);
      ib.id_valid = 1'($urandom); ib.ex_memread = 1'($urandom);
      ia.ex_rd = 5'($urandom_range(0, 3)); ib.ex_rd = 5'($urandom_range(0, 3));
      ia.mem_rd = 5'($urandom_range(0, 3)); ib.mem_rd = 5'($urandom_range(0, 3));
      ia.wb_rd = 5'($urandom_range(0, 3)); ib.wb_rd = 5'($urandom_range(0, 3));
      ia.mem_regwrite = 1'($urandom); ia.wb_regwrite = 1'($urandom);
      ib.mem_regwrite = 1'($urandom); ib.wb_regwrite = 1'($urandom);
      ia.flush = ($urandom_range(0, 7) == 0);
      ib.flush = ($urandom_range(0, 7) == 0);
      #1;
      ef = ref_fwd(3, ia.ex_rs, ia.ex_rs_used, int'(ia.mem_rd),
                   ia.mem_regwrite, int'(ia.wb_rd), ia.wb_regwrite);
      tests++;
      if (ia.forward_sel !== ef) begin
        fails++; $display("FAIL rnd_fwd_a c=%0d got %b want %b", c, ia.forward_sel, ef);
      end
      hz = ref_hz(3, ia.id_rs, ia.id_rs_used, ia.id_valid, ia.ex_memread, int'(ia.ex_rd));
      st = !ia.flush && (rem_a > 0 || hz);
      tests++;
      if ({ia.stall_if, ia.stall_id, ia.bubble_ex} !== {3{st}} ||
          ia.stall_cnt !== 4'(cnt_a)) begin
        fails++;
        $display("FAIL rnd_stall_a c=%0d got %b cnt=%0d want %b cnt=%0d", c,
                 ia.stall_if, ia.stall_cnt, st, cnt_a);
      end
      if (ia.flush) rem_a = 0;
      else if (rem_a > 0) rem_a--;
      else if (hz) rem_a = LAT_A - 1;
      if (st && cnt_a < 15) cnt_a++;
      ef = ref_fwd(2, 15'(ib.ex_rs), 3'(ib.ex_rs_used), int'(ib.mem_rd),
                   ib.mem_regwrite, int'(ib.wb_rd), ib.wb_regwrite);
      tests++;
      if (ib.forward_sel !== ef[3:0]) begin
        fails++; $display("FAIL rnd_fwd_b c=%0d got %b want %b", c, ib.forward_sel, ef[3:0]);
      end
      hz = ref_hz(2, 15'(ib.id_rs), 3'(ib.id_rs_used), ib.id_valid,
                  ib.ex_memread, int'(ib.ex_rd));
      st = !ib.flush && (rem_b > 0 || hz);
      tests++;
      if ({ib.stall_if, ib.stall_id, ib.bubble_ex} !== {3{st}} ||
          ib.stall_cnt !== 32'(cnt_b)) begin
        fails++;
        $display("FAIL rnd_stall_b c=%0d got %b cnt=%0d want %b cnt=%0d", c,
                 ib.stall_if, ib.stall_cnt, st, cnt_b);
      end
      if (ib.flush) rem_b = 0;
      else if (rem_b > 0) rem_b--;
      else if (hz) rem_b = LAT_B - 1;
      if (st) cnt_b++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fwd_directed();
    test_stall_lat1();
    test_stall_lat3();
    test_flush();
    test_saturate_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised successor to the two-operand forwarding unit. It produces per-source bypass selects for any number of EX-stage read operands, using MEM and WB sources with MEM taking priority. It adds a load-use hazard detector with a multi-cycle stall FSM (configurable load latency), flush abort and a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline registers and drives operand muxes and the IF/ID stall and EX bubble controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of source operands per instruction
LOAD_LAT, 1, stall cycles inserted per load-use hazard (>=1)
PERF_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_rs  in  NUM_SRC*REG_AW  EX-stage source addresses, source i at bits [i*REG_AW +: REG_AW]
ex_rs_used  in  NUM_SRC  per-source "operand actually read" in EX
id_rs  in  NUM_SRC*REG_AW  ID-stage source addresses, same packing
id_rs_used  in  NUM_SRC  per-source read flag in ID
id_valid  in  1  ID holds a real instruction
ex_rd  in  REG_AW  EX destination
ex_memread  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM destination
mem_regwrite  in  1  MEM writes register file
wb_rd  in  REG_AW  WB destination
wb_regwrite  in  1  WB writes register file
flush  in  1  branch/exception flush
forward_sel  out  2*NUM_SRC  per-source select, bits [2i+1:2i]
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  load NOP into ID/EX
stall_cnt  out  PERF_W  cycles with stall asserted, saturating

Behaviour:
- Forwarding (combinational), per source i:
  - 01 if mem_regwrite, mem_rd!=0, mem_rd==ex_rs[i] and ex_rs_used[i].
  - Otherwise 10 if the same conditions hold with wb_regwrite and wb_rd.
  - Otherwise 00. Code 11 is never driven.
- Hazard detect (combinational): hz = id_valid & ex_memread & (ex_rd!=0) & OR over i of (id_rs_used[i] & id_rs[i]==ex_rd).
- stall_if = stall_id = bubble_ex = stall. All three are always equal.
- FSM states: IDLE, STALL. Internal counter cnt has width clog2(LOAD_LAT+1).
- IDLE:
  - stall = hz & ~flush.
  - If stall and LOAD_LAT>1: go to STALL, cnt <= LOAD_LAT-1.
  - If stall and LOAD_LAT==1: remain in IDLE. The stall is a single cycle, and next cycle EX holds a bubble, so hz is 0.
- STALL:
  - stall = ~flush.
  - cnt decrements each cycle. When cnt==1 and not flushed, return to IDLE next cycle.
  - Total stall length per hazard is exactly LOAD_LAT cycles.
  - New hazards are not re-evaluated during STALL.
- Flush: has priority in any state. stall=0 that cycle; next state IDLE, cnt <= 0.
- stall_cnt increments on every cycle with stall=1 and holds at 2^PERF_W-1.
- Reset (async): state IDLE, cnt 0, stall_cnt 0. With rst high, all outputs are 0, including forward_sel.
- Reset mid-stall aborts immediately. After release, the FSM is in IDLE and the pipeline re-evaluates hz.
- Simultaneous MEM and WB match on the same source selects MEM (01).
- Register x0 never forwards and never stalls.

Test Plan:
- ex_rs0=5, mem_rd=5 mem_regwrite=1, wb_rd=5 wb_regwrite=1 -> forward_sel[1:0]=01. Drop mem_regwrite -> 10. Set ex_rs_used[0]=0 -> 00.
- NUM_SRC=3, ex_rs={3,7,3}, mem_rd=3, wb_rd=7, both writing -> forward_sel=6'b01_10_01. Set mem_rd=0, wb_rd=0 -> 000000.
- LOAD_LAT=1: ex_memread=1 ex_rd=4, id_rs1=4 used, id_valid=1 -> stall/bubble high exactly 1 cycle; stall_cnt 0->1.
- LOAD_LAT=3: same hazard held only in cycle 0 -> stall high cycles 0,1,2, low at 3; stall_cnt=3. With ex_rd=0 -> no stall.
- LOAD_LAT=3: hazard, then flush in cycle 1 -> stall 1 in cycle 0, 0 from cycle 1; FSM IDLE; stall_cnt=1.
- PERF_W=4: force 20 stall cycles -> stall_cnt saturates at 15. Assert rst mid-STALL -> all outputs 0 asynchronously, stall_cnt=0.
